sram_ctrl: RTL

//  Synchronous master for the asynchronous cs/we/oe SRAM (memory block, default 8-bit address, 4-bit word).

---
 rtl/sram_ctrl_pkg.sv | 28 ++
 rtl/sram_ctrl_phase_counter.sv | 27 ++
 rtl/sram_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding, default
// geometry/timing and the phase-counter width helper.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam int DEF_ADDRESS_SIZE = 8;
    localparam int DEF_WORD_SIZE    = 4;
    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES  = 1;

    // Counter must hold the longest phase length minus one.
    function automatic int phase_cnt_width(input int s, input int p, input int h);
        int m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_phase_counter.sv
// Loadable down-counter that times each strobe phase; o_zero marks the last
// cycle of the current phase.
module sram_ctrl_phase_counter #(
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous master for an asynchronous cs/we/oe SRAM with programmable
// setup/pulse/hold timing; every output comes straight from a flop.
//
// state  | meaning
// IDLE   | ready for a request; wr_done pulses here after a write
// SETUP  | cs high, address/data settling, no strobe
// ACCESS | we (write) or oe (read) strobe asserted
// HOLD   | strobe released, cs and address/data held
// RESP   | read data presented until the consumer takes it
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDRESS_SIZE-1:0] i_req_addr,
    input  logic [WORD_SIZE-1:0]    i_req_wdata,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [WORD_SIZE-1:0]    o_rsp_rdata,
    output logic                    o_wr_done,
    output logic [ADDRESS_SIZE-1:0] o_mem_address,
    output logic [WORD_SIZE-1:0]    o_mem_data_in,
    output logic                    o_mem_cs,
    output logic                    o_mem_we,
    output logic                    o_mem_oe,
    input  logic [WORD_SIZE-1:0]    i_mem_data_out
);

    localparam int CNT_W = phase_cnt_width(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_op_we;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic [WORD_SIZE-1:0]    r_rsp_rdata;
    logic                    r_wr_done;
    logic [ADDRESS_SIZE-1:0] r_mem_address;
    logic [WORD_SIZE-1:0]    r_mem_data_in;
    logic                    r_mem_cs;
    logic                    r_mem_we;
    logic                    r_mem_oe;

    logic                    w_accept;
    logic                    w_phase_zero;
    logic                    w_cnt_load;
    logic [CNT_W-1:0]        w_cnt_load_val;
    logic                    w_req_ready_nxt;
    logic                    w_rsp_valid_nxt;
    logic                    w_wr_done_nxt;
    logic                    w_mem_cs_nxt;
    logic                    w_mem_we_nxt;
    logic                    w_mem_oe_nxt;
    logic                    w_capture;

    assign w_accept = (r_state == ST_IDLE) && i_req_valid && r_req_ready;

    sram_ctrl_phase_counter #(
        .WIDTH (CNT_W)
    ) u_phase_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .o_zero     (w_phase_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)     w_next_state = ST_SETUP;
            ST_SETUP:  if (w_phase_zero) w_next_state = ST_ACCESS;
            ST_ACCESS: if (w_phase_zero) w_next_state = ST_HOLD;
            ST_HOLD:   if (w_phase_zero) w_next_state = r_op_we ? ST_IDLE : ST_RESP;
            ST_RESP:   if (i_rsp_ready)  w_next_state = ST_IDLE;
            default:                     w_next_state = ST_IDLE;
        endcase
    end

    // Each phase starts with length-1 loaded, so the zero flag marks its last cycle.
    always_comb begin
        w_cnt_load     = (w_next_state != r_state);
        w_cnt_load_val = '0;
        case (w_next_state)
            ST_SETUP:  w_cnt_load_val = CNT_W'(SETUP_CYCLES - 1);
            ST_ACCESS: w_cnt_load_val = CNT_W'(PULSE_CYCLES - 1);
            ST_HOLD:   w_cnt_load_val = CNT_W'(HOLD_CYCLES - 1);
            default:   w_cnt_load_val = '0;
        endcase
    end

    always_comb begin
        w_req_ready_nxt = (w_next_state == ST_IDLE);
        w_rsp_valid_nxt = (w_next_state == ST_RESP);
        w_wr_done_nxt   = (r_state == ST_HOLD) && w_phase_zero && r_op_we;
        w_mem_cs_nxt    = (w_next_state == ST_SETUP) || (w_next_state == ST_ACCESS)
                          || (w_next_state == ST_HOLD);
        w_mem_we_nxt    = (w_next_state == ST_ACCESS) && r_op_we;
        w_mem_oe_nxt    = (w_next_state == ST_ACCESS) && !r_op_we;
        w_capture       = (r_state == ST_ACCESS) && w_phase_zero && !r_op_we;
    end

    // Strobes are decoded from the next state so they leave a flop edge-aligned with the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_we       <= 1'b0;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_wr_done     <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_mem_cs      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_oe      <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_wr_done   <= w_wr_done_nxt;
            r_mem_cs    <= w_mem_cs_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_oe    <= w_mem_oe_nxt;
            if (w_accept) begin
                r_op_we       <= i_req_we;
                r_mem_address <= i_req_addr;
                if (i_req_we) begin
                    r_mem_data_in <= i_req_wdata;
                end
            end
            if (w_capture) begin
                r_rsp_rdata <= i_mem_data_out;
            end
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_wr_done     = r_wr_done;
    assign o_mem_address = r_mem_address;
    assign o_mem_data_in = r_mem_data_in;
    assign o_mem_cs      = r_mem_cs;
    assign o_mem_we      = r_mem_we;
    assign o_mem_oe      = r_mem_oe;

endmodule
